pipeline_control: RTL and testbench
===================================

PIPELINE_CONTROL -- requirements
Module: pipeline_control

Interface
REQ-001 Parameter OPW, default 6, opcode field width.
REQ-002 Parameter FNW, default 6, funct field width.
REQ-003 Parameter RAW, default 5, register-address width.
REQ-004 Parameter AOW, default 2, ALUOp width; values above 2 SHALL zero-extend the encodings of REQ-013.
REQ-005 clk  in  1  single clock, all state on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 id_opcode  in  OPW  opcode of instruction in ID.
REQ-008 id_funct  in  FNW  funct of instruction in ID.
REQ-009 id_rs, id_rt  in  RAW each  source registers of instruction in ID.
REQ-010 flush  in  1  branch/jump taken; squash ID/EX and EX/MEM.
REQ-011 Outputs, all registered: ex_regdst(1), ex_alusrc(1), ex_aluop(AOW), ex_rt(RAW), ex_illegal(1) [ID/EX]; mem_read(2), mem_write(2), mem_branch(2), mem_jump(2), mem_link(1) [EX/MEM]; wb_regwrite(1), wb_memtoreg(1), wb_link(1) [MEM/WB]. Hazard output hazard_stall(1) is combinational.

Function
REQ-012 Decode (ID, combinational), any unlisted opcode decodes to bubble with illegal=1.
REQ-013 Decode table as regdst/alusrc/aluop/read/write/branch/jump/link/regwrite/memtoreg: R-type 000000 (funct!=001000): 1/0/00/00/00/00/00/0/1/0; jr 000000+funct 001000: 0/0/00/00/00/00/11/0/0/0; lw 100011: 0/1/01/01/00/00/00/0/1/1; lb 100000: read=10 else as lw; lh 100001: read=11 else as lw; sw 101011: 0/1/01/00/01/00/00/0/0/0; sb 101000: write=10 else as sw; sh 101001: write=11 else as sw; andi 001100 and ori 001101: 0/1/11/00/00/00/00/0/1/0; lui 001111: 0/1/01/00/00/00/00/0/1/0; beq 000100: 0/0/10/00/00/01/00/0/0/0; bne 000101: branch=10 else as beq; bgez 000001: branch=11 else as beq; j 000010: all 0 except jump=01; jal 000011: jump=10, link=1, regwrite=1, else 0.
REQ-014 Bubble = all control bits 0, ex_rt=0; no don't-care values anywhere.
REQ-015 hazard_stall=1 when ID/EX holds a load (mem_read field !=00), its rt !=0, and rt equals id_rs or id_rt; else 0.
REQ-016 Each rising edge: ID/EX <= decode(ID) and ex_rt <= id_rt, unless hazard_stall or flush, then ID/EX <= bubble.
REQ-017 Each rising edge: EX/MEM <= ID/EX fields, unless flush, then EX/MEM <= bubble.
REQ-018 Each rising edge: MEM/WB <= EX/MEM fields; never squashed by flush.
REQ-019 Latency: opcode in ID at edge N appears on ex_* after N, mem_* after N+1, wb_* after N+2.
REQ-020 Priority: reset > flush > hazard_stall > normal advance.
REQ-021 hazard_stall SHALL not hold the upstream ID input; holding IF/ID is the consumer's job.
REQ-022 ex_illegal SHALL be one-cycle per illegal instruction, cleared by bubble or next decode.

Reset
REQ-023 With rst_n=0 at a rising edge, all three stage registers SHALL load bubble; all registered outputs 0 after that edge.
REQ-024 Reset mid-operation SHALL discard every in-flight instruction; hazard_stall SHALL be 0 the cycle after reset.

Verification
REQ-025 Reset, then lw (100011) at edge 1 -> ex_alusrc=1, ex_aluop=01 after edge 1; mem_read=01 after edge 2; wb_regwrite=1, wb_memtoreg=1 after edge 3.
REQ-026 lw rt=5 then add with id_rs=5 -> hazard_stall=1; next edge ex_* all 0; mem_read=01 continues to MEM.
REQ-027 lw rt=0 then id_rs=0 -> hazard_stall=0, no bubble.
REQ-028 beq in EX/MEM with flush=1 asserted same edge as sh in ID -> ID/EX and EX/MEM bubble, mem_write!=11; MEM/WB receives beq fields.
REQ-029 Opcode 111111 -> ex_illegal=1 one cycle, all other controls 0; jal -> mem_jump=10, wb_link=1, wb_regwrite=1.
REQ-030 rst_n=0 while sw in EX/MEM -> after that edge mem_write=00 and all outputs 0.

Source files
------------

// File: rtl/pipeline_control.sv
// Pipeline control: ID decode, load-use hazard detection and the ID/EX,
// EX/MEM and MEM/WB control registers with flush squashing.
module pipeline_control #(
  parameter int OPW = 6,
  parameter int FNW = 6,
  parameter int RAW = 5,
  parameter int AOW = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [OPW-1:0] id_opcode,
  input  logic [FNW-1:0] id_funct,
  input  logic [RAW-1:0] id_rs,
  input  logic [RAW-1:0] id_rt,
  input  logic           flush,
  output logic           ex_regdst,
  output logic           ex_alusrc,
  output logic [AOW-1:0] ex_aluop,
  output logic [RAW-1:0] ex_rt,
  output logic           ex_illegal,
  output logic [1:0]     mem_read,
  output logic [1:0]     mem_write,
  output logic [1:0]     mem_branch,
  output logic [1:0]     mem_jump,
  output logic           mem_link,
  output logic           wb_regwrite,
  output logic           wb_memtoreg,
  output logic           wb_link,
  output logic           hazard_stall
);

  localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
  localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
  localparam logic [OPW-1:0] OP_LB    = OPW'(6'b100000);
  localparam logic [OPW-1:0] OP_LH    = OPW'(6'b100001);
  localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);
  localparam logic [OPW-1:0] OP_SB    = OPW'(6'b101000);
  localparam logic [OPW-1:0] OP_SH    = OPW'(6'b101001);
  localparam logic [OPW-1:0] OP_ANDI  = OPW'(6'b001100);
  localparam logic [OPW-1:0] OP_ORI   = OPW'(6'b001101);
  localparam logic [OPW-1:0] OP_LUI   = OPW'(6'b001111);
  localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
  localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);
  localparam logic [OPW-1:0] OP_BGEZ  = OPW'(6'b000001);
  localparam logic [OPW-1:0] OP_J     = OPW'(6'b000010);
  localparam logic [OPW-1:0] OP_JAL   = OPW'(6'b000011);
  localparam logic [FNW-1:0] FN_JR    = FNW'(6'b001000);

  typedef struct packed {
    logic           regdst;
    logic           alusrc;
    logic [AOW-1:0] aluop;
    logic           illegal;
    logic [1:0]     rd;
    logic [1:0]     wr;
    logic [1:0]     br;
    logic [1:0]     jp;
    logic           lk;
    logic           rw;
    logic           m2r;
    logic [RAW-1:0] rt;
  } idex_t;

  typedef struct packed {
    logic [1:0] rd;
    logic [1:0] wr;
    logic [1:0] br;
    logic [1:0] jp;
    logic       lk;
    logic       rw;
    logic       m2r;
  } exmem_t;

  typedef struct packed {
    logic rw;
    logic m2r;
    logic lk;
  } memwb_t;

  idex_t  dec, idex_d, idex_q;
  exmem_t exmem_d, exmem_q;
  memwb_t memwb_d, memwb_q;

  always_comb begin
    dec = '0;
    case (id_opcode)
      OP_RTYPE: begin
        if (id_funct == FN_JR) begin
          dec.jp = 2'b11;
        end else begin
          dec.regdst = 1'b1;
          dec.rw     = 1'b1;
        end
      end
      OP_LW, OP_LB, OP_LH: begin
        dec.alusrc = 1'b1;
        dec.aluop  = AOW'(2'b01);
        dec.rw     = 1'b1;
        dec.m2r    = 1'b1;
        dec.rd     = (id_opcode == OP_LB) ? 2'b10 : (id_opcode == OP_LH) ? 2'b11 : 2'b01;
      end
      OP_SW, OP_SB, OP_SH: begin
        dec.alusrc = 1'b1;
        dec.aluop  = AOW'(2'b01);
        dec.wr     = (id_opcode == OP_SB) ? 2'b10 : (id_opcode == OP_SH) ? 2'b11 : 2'b01;
      end
      OP_ANDI, OP_ORI: begin
        dec.alusrc = 1'b1;
        dec.aluop  = AOW'(2'b11);
        dec.rw     = 1'b1;
      end
      OP_LUI: begin
        dec.alusrc = 1'b1;
        dec.aluop  = AOW'(2'b01);
        dec.rw     = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BGEZ: begin
        dec.aluop = AOW'(2'b10);
        dec.br    = (id_opcode == OP_BNE) ? 2'b10 : (id_opcode == OP_BGEZ) ? 2'b11 : 2'b01;
      end
      OP_J:    dec.jp = 2'b01;
      OP_JAL: begin
        dec.jp = 2'b10;
        dec.lk = 1'b1;
        dec.rw = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    // an illegal opcode is a bubble, so it carries no destination register
    if (!dec.illegal) dec.rt = id_rt;
  end

  always_comb begin
    hazard_stall = (idex_q.rd != 2'b00) && (idex_q.rt != '0) &&
                   ((idex_q.rt == id_rs) || (idex_q.rt == id_rt));
  end

  always_comb begin
    idex_d = (flush || hazard_stall) ? '0 : dec;

    exmem_d = '0;
    if (!flush) begin
      exmem_d.rd  = idex_q.rd;
      exmem_d.wr  = idex_q.wr;
      exmem_d.br  = idex_q.br;
      exmem_d.jp  = idex_q.jp;
      exmem_d.lk  = idex_q.lk;
      exmem_d.rw  = idex_q.rw;
      exmem_d.m2r = idex_q.m2r;
    end

    memwb_d.rw  = exmem_q.rw;
    memwb_d.m2r = exmem_q.m2r;
    memwb_d.lk  = exmem_q.lk;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idex_q  <= '0;
      exmem_q <= '0;
      memwb_q <= '0;
    end else begin
      idex_q  <= idex_d;
      exmem_q <= exmem_d;
      memwb_q <= memwb_d;
    end
  end

  assign ex_regdst   = idex_q.regdst;
  assign ex_alusrc   = idex_q.alusrc;
  assign ex_aluop    = idex_q.aluop;
  assign ex_rt       = idex_q.rt;
  assign ex_illegal  = idex_q.illegal;
  assign mem_read    = exmem_q.rd;
  assign mem_write   = exmem_q.wr;
  assign mem_branch  = exmem_q.br;
  assign mem_jump    = exmem_q.jp;
  assign mem_link    = exmem_q.lk;
  assign wb_regwrite = memwb_q.rw;
  assign wb_memtoreg = memwb_q.m2r;
  assign wb_link     = memwb_q.lk;

endmodule

// File: tb/tb_pipeline_control.sv
// Self-checking bench for pipeline_control: directed scenarios plus random
// instruction streams compared against a table-driven pipeline model.
module tb_pipeline_control;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] id_opcode, id_funct;
  logic [4:0] id_rs, id_rt;
  logic       flush;
  logic       ex_regdst, ex_alusrc, ex_illegal;
  logic [1:0] ex_aluop;
  logic [4:0] ex_rt;
  logic [1:0] mem_read, mem_write, mem_branch, mem_jump;
  logic       mem_link, wb_regwrite, wb_memtoreg, wb_link, hazard_stall;

  pipeline_control dut (
    .clk(clk), .rst_n(rst_n), .id_opcode(id_opcode), .id_funct(id_funct),
    .id_rs(id_rs), .id_rt(id_rt), .flush(flush),
    .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc), .ex_aluop(ex_aluop),
    .ex_rt(ex_rt), .ex_illegal(ex_illegal),
    .mem_read(mem_read), .mem_write(mem_write), .mem_branch(mem_branch),
    .mem_jump(mem_jump), .mem_link(mem_link),
    .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_link(wb_link),
    .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       regdst, alusrc;
    logic [1:0] aluop;
    logic       illegal;
    logic [1:0] rd, wr, br, jp;
    logic       lk, rw, m2r;
    logic [4:0] rt;
  } st_t;

  st_t  m_ex, m_mem, m_wb;
  logic m_haz, last_haz;
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected controls, one row per opcode of the decode table.
  function automatic st_t ref_decode(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] rt);
    st_t s = '0;
    case (op)
      6'o00: if (fn == 6'o10) s.jp = 2'd3; else begin s.regdst = 1; s.rw = 1; end
      6'o43: begin s.alusrc = 1; s.aluop = 1; s.rd = 1; s.rw = 1; s.m2r = 1; end
      6'o40: begin s.alusrc = 1; s.aluop = 1; s.rd = 2; s.rw = 1; s.m2r = 1; end
      6'o41: begin s.alusrc = 1; s.aluop = 1; s.rd = 3; s.rw = 1; s.m2r = 1; end
      6'o53: begin s.alusrc = 1; s.aluop = 1; s.wr = 1; end
      6'o50: begin s.alusrc = 1; s.aluop = 1; s.wr = 2; end
      6'o51: begin s.alusrc = 1; s.aluop = 1; s.wr = 3; end
      6'o14, 6'o15: begin s.alusrc = 1; s.aluop = 3; s.rw = 1; end
      6'o17: begin s.alusrc = 1; s.aluop = 1; s.rw = 1; end
      6'o04: begin s.aluop = 2; s.br = 1; end
      6'o05: begin s.aluop = 2; s.br = 2; end
      6'o01: begin s.aluop = 2; s.br = 3; end
      6'o02: s.jp = 1;
      6'o03: begin s.jp = 2; s.lk = 1; s.rw = 1; end
      default: s.illegal = 1;
    endcase
    if (!s.illegal) s.rt = rt;
    return s;
  endfunction

  task automatic check_outputs(input string tag);
    check_eq({tag, "_ex"}, 32'({ex_regdst, ex_alusrc, ex_aluop, ex_illegal, ex_rt}),
             32'({m_ex.regdst, m_ex.alusrc, m_ex.aluop, m_ex.illegal, m_ex.rt}));
    check_eq({tag, "_mem"}, 32'({mem_read, mem_write, mem_branch, mem_jump, mem_link}),
             32'({m_mem.rd, m_mem.wr, m_mem.br, m_mem.jp, m_mem.lk}));
    check_eq({tag, "_wb"}, 32'({wb_regwrite, wb_memtoreg, wb_link}),
             32'({m_wb.rw, m_wb.m2r, m_wb.lk}));
  endtask

  // Drive one ID-stage instruction for one clock and check all stages.
  task automatic step(input string tag, input logic rst, input logic [5:0] op,
                      input logic [5:0] fn, input logic [4:0] rs, input logic [4:0] rt,
                      input logic fl);
    rst_n = rst; id_opcode = op; id_funct = fn; id_rs = rs; id_rt = rt; flush = fl;
    #1;
    m_haz = (m_ex.rd != 0) && (m_ex.rt != 0) && (m_ex.rt == rs || m_ex.rt == rt);
    last_haz = hazard_stall;
    check_eq({tag, "_haz"}, 32'(hazard_stall), 32'(m_haz));
    @(posedge clk);
    if (!rst) begin
      m_ex = '0; m_mem = '0; m_wb = '0;
    end else begin
      m_wb  = m_mem;
      m_mem = fl ? '0 : m_ex;
      m_ex  = (fl || m_haz) ? '0 : ref_decode(op, fn, rt);
    end
    #1;
    check_outputs(tag);
  endtask

  logic [5:0] legal_ops [15] = '{6'o00, 6'o43, 6'o40, 6'o41, 6'o53, 6'o50, 6'o51, 6'o14,
                                 6'o15, 6'o17, 6'o04, 6'o05, 6'o01, 6'o02, 6'o03};

  initial begin
    rst_n = 0; id_opcode = 0; id_funct = 0; id_rs = 0; id_rt = 0; flush = 0;
    repeat (2) @(posedge clk);
    #1;
    m_ex = '0; m_mem = '0; m_wb = '0;
    check_outputs("reset");
    check_eq("reset_haz", 32'(hazard_stall), 32'd0);

    // lw through all three stages, with a dependent add stalled behind it
    step("lw", 1, 6'o43, 6'd0, 5'd1, 5'd5, 0);
    check_eq("lw_alusrc", 32'(ex_alusrc), 32'd1);
    check_eq("lw_aluop", 32'(ex_aluop), 32'd1);
    step("add_dep", 1, 6'o00, 6'h20, 5'd5, 5'd6, 0);
    check_eq("loaduse_stall", 32'(last_haz), 32'd1);
    check_eq("loaduse_bubble", 32'({ex_regdst, ex_alusrc, ex_aluop, ex_illegal, ex_rt}), 32'd0);
    check_eq("lw_memread", 32'(mem_read), 32'd1);
    step("add_rep", 1, 6'o00, 6'h20, 5'd5, 5'd6, 0);
    check_eq("lw_wb", 32'({wb_regwrite, wb_memtoreg}), 32'd3);

    // load to r0 never stalls
    step("lw_r0", 1, 6'o43, 6'd0, 5'd2, 5'd0, 0);
    step("use_r0", 1, 6'o00, 6'h20, 5'd0, 5'd0, 0);
    check_eq("r0_nostall", 32'(last_haz), 32'd0);
    check_eq("r0_advance", 32'(ex_regdst), 32'd1);

    // flush with beq in EX/MEM and sh in ID
    step("beq", 1, 6'o04, 6'd0, 5'd1, 5'd2, 0);
    step("or_after", 1, 6'o15, 6'd0, 5'd3, 5'd7, 0);
    step("sh_flush", 1, 6'o51, 6'd0, 5'd1, 5'd2, 1);
    check_eq("flush_memwrite", 32'(mem_write), 32'd0);

    // illegal opcode is one cycle only, then jal down the pipe
    step("illegal", 1, 6'o77, 6'd0, 5'd1, 5'd9, 0);
    check_eq("illegal_flag", 32'(ex_illegal), 32'd1);
    step("jal", 1, 6'o03, 6'd0, 5'd0, 5'd31, 0);
    check_eq("illegal_clear", 32'(ex_illegal), 32'd0);
    step("nop1", 1, 6'o00, 6'h20, 5'd0, 5'd0, 0);
    check_eq("jal_memjump", 32'(mem_jump), 32'd2);
    step("nop2", 1, 6'o00, 6'h20, 5'd0, 5'd0, 0);
    check_eq("jal_wb", 32'({wb_link, wb_regwrite}), 32'd3);

    // reset with sw in EX/MEM
    step("sw", 1, 6'o53, 6'd0, 5'd1, 5'd2, 0);
    step("sw_adv", 1, 6'o00, 6'h20, 5'd3, 5'd4, 0);
    step("midreset", 0, 6'o43, 6'd0, 5'd1, 5'd3, 0);
    check_eq("reset_memwrite", 32'(mem_write), 32'd0);
    step("post_reset", 1, 6'o00, 6'h20, 5'd3, 5'd3, 0);

    for (int i = 0; i < 600; i++) begin
      logic [5:0] op, fn;
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 14)];
      fn = ($urandom_range(0, 3) == 0) ? 6'o10 : 6'($urandom);
      step("rand", $urandom_range(0, 39) != 0, op, fn,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
